// File: rtl/mod_clock_sequencer.sv
// Power-up clock sequencer for the NES core: qualifies PLL lock, holds the core in reset
// until lock is stable, then generates PPU/CPU/APU clock enables. Optional lock-loss
// counter is built when MOD_CLOCK_SEQUENCER_LOSS_COUNT_EN is defined.
module mod_clock_sequencer #(
  parameter int SETTLE_CYCLES = 1024,
  parameter int PPU_DIV       = 4
) (
  input  logic       in_clk_25_175_mhz,
  input  logic       in_rst,
  input  logic       in_pll_lock,
  output logic       out_rst,
  output logic       out_run,
  output logic       out_ppu_ce,
  output logic       out_cpu_ce,
  output logic       out_apu_ce
`ifdef MOD_CLOCK_SEQUENCER_LOSS_COUNT_EN
  ,
  output logic [7:0] out_lock_loss_count
`endif
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  PRE_LAST    = 8'(PPU_DIV - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'b00,
    SETTLE    = 2'b01,
    RUN       = 2'b10
  } state_t;

  logic        rst_meta;
  logic        rst_sync;
  logic        lock_meta;
  logic        lock_s;
  state_t      state;
  state_t      state_next;
  logic [15:0] settle_cnt;
  logic [15:0] settle_cnt_next;
  logic [7:0]  prescaler;
  logic [1:0]  phase;
  logic        toggle;
  logic        run;
  logic        hold;
  logic        ppu_ce;
  logic        cpu_ce;
  logic        apu_ce;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge in_clk_25_175_mhz or posedge in_rst) begin
    if (in_rst) begin
      rst_meta <= 1'b1;
      rst_sync <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_sync <= rst_meta;
    end
  end

  always_ff @(posedge in_clk_25_175_mhz or posedge in_rst) begin
    if (in_rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= in_pll_lock;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge in_clk_25_175_mhz or posedge rst_sync) begin
    if (rst_sync) begin
      state      <= WAIT_LOCK;
      settle_cnt <= 16'd0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
    end
  end

  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_next      = SETTLE;
          settle_cnt_next = 16'd0;
        end
      end
      SETTLE: begin
        // A lock drop wins even on the final settle cycle.
        if (!lock_s) begin
          state_next      = WAIT_LOCK;
          settle_cnt_next = 16'd0;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_next      = RUN;
          settle_cnt_next = 16'd0;
        end else begin
          settle_cnt_next = settle_cnt + 16'd1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
        end
      end
      default: begin
        state_next      = WAIT_LOCK;
        settle_cnt_next = 16'd0;
      end
    endcase
  end

  assign run  = (state == RUN);
  assign hold = (state != RUN) || (state_next != RUN);

  // Divider chain starts from zero on every RUN entry so the first PPU enable
  // lands on the PPU_DIV-th RUN cycle.
  always_ff @(posedge in_clk_25_175_mhz or posedge rst_sync) begin
    if (rst_sync) begin
      prescaler <= 8'd0;
      phase     <= 2'd0;
      toggle    <= 1'b0;
    end else if (hold) begin
      prescaler <= 8'd0;
      phase     <= 2'd0;
      toggle    <= 1'b0;
    end else begin
      prescaler <= (prescaler == PRE_LAST) ? 8'd0 : prescaler + 8'd1;
      if (ppu_ce) begin
        phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
      end
      if (cpu_ce) begin
        toggle <= ~toggle;
      end
    end
  end

  assign ppu_ce = run && (prescaler == PRE_LAST);
  assign cpu_ce = ppu_ce && (phase == 2'd2);
  assign apu_ce = cpu_ce && toggle;

  assign out_rst    = ~run;
  assign out_run    = run;
  assign out_ppu_ce = ppu_ce;
  assign out_cpu_ce = cpu_ce;
  assign out_apu_ce = apu_ce;

`ifdef MOD_CLOCK_SEQUENCER_LOSS_COUNT_EN
  logic [7:0] loss_cnt;

  always_ff @(posedge in_clk_25_175_mhz or posedge rst_sync) begin
    if (rst_sync) begin
      loss_cnt <= 8'd0;
    end else if (run && (state_next == WAIT_LOCK) && (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end

  assign out_lock_loss_count = loss_cnt;
`else
  // Lock-loss statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_mod_clock_sequencer.sv
// Self-checking bench for mod_clock_sequencer: directed timing checks on the default
// configuration, a vector table for PPU_DIV=1, and a randomized run against a lock-streak model.
module tb_mod_clock_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, lock0, rst1, lock1, rst2, lock2;
  logic r0_rst, r0_run, r0_ppu, r0_cpu, r0_apu;
  logic r1_rst, r1_run, r1_ppu, r1_cpu, r1_apu;
  logic r2_rst, r2_run, r2_ppu, r2_cpu, r2_apu;
`ifdef MOD_CLOCK_SEQUENCER_LOSS_COUNT_EN
  logic [7:0] cnt0, cnt1, cnt2;
`endif

  logic [4:0] o0, o1, o2;
  assign o0 = {r0_rst, r0_run, r0_ppu, r0_cpu, r0_apu};
  assign o1 = {r1_rst, r1_run, r1_ppu, r1_cpu, r1_apu};
  assign o2 = {r2_rst, r2_run, r2_ppu, r2_cpu, r2_apu};

  mod_clock_sequencer dut0 (
    .in_clk_25_175_mhz(clk), .in_rst(rst0), .in_pll_lock(lock0),
    .out_rst(r0_rst), .out_run(r0_run), .out_ppu_ce(r0_ppu),
    .out_cpu_ce(r0_cpu), .out_apu_ce(r0_apu)
`ifdef MOD_CLOCK_SEQUENCER_LOSS_COUNT_EN
    , .out_lock_loss_count(cnt0)
`endif
  );

  mod_clock_sequencer #(.SETTLE_CYCLES(7), .PPU_DIV(1)) dut1 (
    .in_clk_25_175_mhz(clk), .in_rst(rst1), .in_pll_lock(lock1),
    .out_rst(r1_rst), .out_run(r1_run), .out_ppu_ce(r1_ppu),
    .out_cpu_ce(r1_cpu), .out_apu_ce(r1_apu)
`ifdef MOD_CLOCK_SEQUENCER_LOSS_COUNT_EN
    , .out_lock_loss_count(cnt1)
`endif
  );

  localparam int S2 = 5;
  localparam int D2 = 3;
  mod_clock_sequencer #(.SETTLE_CYCLES(S2), .PPU_DIV(D2)) dut2 (
    .in_clk_25_175_mhz(clk), .in_rst(rst2), .in_pll_lock(lock2),
    .out_rst(r2_rst), .out_run(r2_run), .out_ppu_ce(r2_ppu),
    .out_cpu_ce(r2_cpu), .out_apu_ce(r2_apu)
`ifdef MOD_CLOCK_SEQUENCER_LOSS_COUNT_EN
    , .out_lock_loss_count(cnt2)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       lock;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[18];

  localparam int NV = 6600;
  logic lk[NV];

  int found, edge_at, n;
  int streak, kk, losses, seg_left;
  logic cur, ls, run_m, prev_run;
  logic [4:0] exp5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {rst, run, ppu, cpu, apu} on the k-th RUN cycle (k starts at 1).
  function automatic logic [4:0] run_exp(input int k, input int d);
    return {1'b0, 1'b1, (k % d) == 0, (k % (3 * d)) == 0, (k % (6 * d)) == 0};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    lock0 = 1'b0; lock1 = 1'b0; lock2 = 1'b0;
    #2;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    repeat (3) tick();
    check("reset_dut0", 32'(o0), 32'b10000);
    check("reset_dut1", 32'(o1), 32'b10000);
    check("reset_dut2", 32'(o2), 32'b10000);
`ifdef MOD_CLOCK_SEQUENCER_LOSS_COUNT_EN
    check("reset_cnt0", 32'(cnt0), 32'd0);
`endif
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    repeat (5) tick();
    check("post_reset_idle", 32'(o0), 32'b10000);

    // Lock raised just after edge 0; release expected at edge 1027.
    tick();
    lock0 = 1'b1;
    found = 0; edge_at = 0;
    for (int e = 1; e <= 1100 && found == 0; e++) begin
      tick();
      if (!r0_rst) begin found = 1; edge_at = e; end
    end
    check("settle_release_edge", 32'(edge_at), 32'd1027);
    check("run_k1", 32'(o0), 32'(run_exp(1, 4)));
    for (int k = 2; k <= 48; k++) begin
      tick();
      check($sformatf("div4_k%0d", k), 32'(o0), 32'(run_exp(k, 4)));
    end

    // Asynchronous abort on a CPU-enable cycle.
    n = 0;
    while (!r0_cpu && n < 30) begin tick(); n++; end
    check("cpu_ce_before_abort", 32'(r0_cpu), 32'd1);
    rst0 = 1'b1;
    #1;
    check("abort_async", 32'(o0), 32'b10000);
    tick(); tick();
    check("abort_held", 32'(o0), 32'b10000);
    rst0 = 1'b0;
    found = 0; edge_at = 0;
    for (int e = 1; e <= 1100 && found == 0; e++) begin
      tick();
      if (!r0_rst) begin found = 1; edge_at = e; end
    end
    check("requalify_edge", 32'(edge_at), 32'd1027);
    check("requal_k1", 32'(o0), 32'(run_exp(1, 4)));
    for (int k = 2; k <= 24; k++) begin
      tick();
      check($sformatf("requal_k%0d", k), 32'(o0), 32'(run_exp(k, 4)));
    end

    // Lock loss in RUN.
`ifdef MOD_CLOCK_SEQUENCER_LOSS_COUNT_EN
    check("loss_cnt_before", 32'(cnt0), 32'd0);
`endif
    lock0 = 1'b0;
    tick(); tick();
    check("loss_still_run_2", 32'(o0[3]), 32'd1);
    tick();
    check("loss_within_3", 32'(o0), 32'b10000);
`ifdef MOD_CLOCK_SEQUENCER_LOSS_COUNT_EN
    check("loss_cnt_after", 32'(cnt0), 32'd1);
`endif

    // One-cycle glitch during SETTLE forces a full new qualification.
    tick();
    lock0 = 1'b1;
    found = 0; edge_at = 0;
    for (int e = 1; e <= 1600 && found == 0; e++) begin
      tick();
      if (!r0_rst) begin found = 1; edge_at = e; end
      if (e == 503) lock0 = 1'b0;
      if (e == 504) lock0 = 1'b1;
    end
    check("glitch_release_edge", 32'(edge_at), 32'd1531);
    lock0 = 1'b0;

    // PPU_DIV=1, SETTLE_CYCLES=7 vector table.
    for (int i = 0; i <= 8; i++) tbl[i] = '{1'b1, 5'b10000};
    tbl[9]  = '{1'b1, 5'b01100};
    tbl[10] = '{1'b1, 5'b01100};
    tbl[11] = '{1'b1, 5'b01110};
    tbl[12] = '{1'b1, 5'b01100};
    tbl[13] = '{1'b1, 5'b01100};
    tbl[14] = '{1'b0, 5'b01111};
    tbl[15] = '{1'b0, 5'b01100};
    tbl[16] = '{1'b0, 5'b10000};
    tbl[17] = '{1'b1, 5'b10000};
    for (int i = 0; i < 18; i++) begin
      lock1 = tbl[i].lock;
      tick();
      check($sformatf("tbl_div1_%0d", i), 32'(o1), 32'(tbl[i].exp));
    end
    lock1 = 1'b0;

    // Randomized lock pattern, then 300 forced losses, against the streak model.
    streak = 0; kk = 0; losses = 0; prev_run = 1'b0;
    cur = 1'b0; seg_left = 0;
    for (int j = 0; j < NV; j++) begin
      if (j < 2000) begin
        if (seg_left == 0) begin
          cur = ~cur;
          seg_left = cur ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 4));
        end
        seg_left--;
        lk[j] = cur;
      end else begin
        lk[j] = ((j - 2000) % 15) < 12;
      end
      lock2 = lk[j];
      tick();
      ls = (j >= 2) ? lk[j - 2] : 1'b0;
      streak = ls ? streak + 1 : 0;
      run_m = (streak >= S2 + 1);
      kk = run_m ? kk + 1 : 0;
      if (prev_run && !run_m && losses < 255) losses++;
      prev_run = run_m;
      exp5 = run_m ? run_exp(kk, D2) : 5'b10000;
      check($sformatf("rand_v%0d", j), 32'(o2), 32'(exp5));
`ifdef MOD_CLOCK_SEQUENCER_LOSS_COUNT_EN
      check($sformatf("rand_cnt_v%0d", j), 32'(cnt2), 32'(losses));
`endif
    end
    lock2 = 1'b0;
`ifdef MOD_CLOCK_SEQUENCER_LOSS_COUNT_EN
    check("loss_saturate", 32'(cnt2), 32'd255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_clock_sequencer.md
MOD_CLOCK_SEQUENCER -- requirements
Module: mod_clock_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1024: cycles of continuous PLL lock required before release; legal 1..65535.
REQ-002 Parameter PPU_DIV, default 4: in_clk cycles per PPU clock enable; legal 1..255.
REQ-003 in_clk_25_175_mhz  input  1  sole clock, from the PLL output; all logic on its rising edge.
REQ-004 in_rst  input  1  asynchronous, active-high reset.
REQ-005 in_pll_lock  input  1  PLL LOCK, asynchronous to in_clk_25_175_mhz.
REQ-006 out_rst  output  1  active-high system reset for NES core logic.
REQ-007 out_run  output  1  high while the sequencer is in RUN.
REQ-008 out_ppu_ce  output  1  single-cycle PPU clock enable.
REQ-009 out_cpu_ce  output  1  single-cycle CPU clock enable (PPU/3).
REQ-010 out_apu_ce  output  1  single-cycle APU clock enable (CPU/2).
REQ-011 out_lock_loss_count  output  8  saturating count of lock losses while in RUN (present only per REQ-030).

Function
REQ-012 in_pll_lock SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized value (lock_s).
REQ-013 The FSM SHALL have states WAIT_LOCK, SETTLE and RUN, encoded in 2 bits; encoding 2'b11 SHALL transition to WAIT_LOCK.
REQ-014 WAIT_LOCK: lock_s=1 -> SETTLE with settle counter cleared to 0; otherwise remain.
REQ-015 SETTLE: lock_s=0 -> WAIT_LOCK, counter cleared; lock_s=1 and counter==SETTLE_CYCLES-1 -> RUN; otherwise counter increments by 1.
REQ-016 RUN: lock_s=0 -> WAIT_LOCK on the next edge; otherwise remain.
REQ-017 out_rst SHALL be high whenever state!=RUN and low in RUN; out_run SHALL equal (state==RUN).
REQ-018 Prescaler (8 bit) SHALL be 0 on RUN entry, count 0..PPU_DIV-1 and wrap to 0 in RUN; it SHALL be held at 0 outside RUN.
REQ-019 out_ppu_ce SHALL be high exactly when state==RUN and prescaler==PPU_DIV-1; with PPU_DIV=1 it SHALL be high every RUN cycle.
REQ-020 A PPU phase counter SHALL count 0,1,2,0 on each out_ppu_ce; out_cpu_ce SHALL be high when out_ppu_ce=1 and phase==2.
REQ-021 An APU toggle SHALL flip on each out_cpu_ce; out_apu_ce SHALL be high when out_cpu_ce=1 and toggle==1.
REQ-022 Phase counter and toggle SHALL be cleared to 0 whenever state!=RUN.
REQ-023 All enables SHALL be low whenever state!=RUN, including the first WAIT_LOCK cycle after lock loss.
REQ-024 Lock loss in SETTLE on the cycle counter==SETTLE_CYCLES-1 SHALL go to WAIT_LOCK, not RUN.

Reset
REQ-025 in_rst=1 SHALL asynchronously force state=WAIT_LOCK, the synchronizer flops, settle counter, prescaler, phase counter and toggle to 0.
REQ-026 During reset: out_rst=1, out_run=0, out_ppu_ce=0, out_cpu_ce=0, out_apu_ce=0, out_lock_loss_count=0.
REQ-027 in_rst asserted mid-RUN or mid-SETTLE SHALL abort immediately; after release, the full SETTLE_CYCLES qualification SHALL repeat.
REQ-028 in_rst deassertion SHALL be synchronized to in_clk_25_175_mhz (2-flop release) before the FSM leaves reset.

Configuration
REQ-029 Macro MOD_CLOCK_SEQUENCER_LOSS_COUNT_EN SHALL control the lock-loss counter.
REQ-030 Defined: out_lock_loss_count SHALL increment by 1 on each RUN->WAIT_LOCK transition and saturate at 255. It SHALL be cleared only by in_rst.
REQ-031 Undefined: the port out_lock_loss_count and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification (defaults SETTLE_CYCLES=1024, PPU_DIV=4)
REQ-032 Release in_rst, then raise in_pll_lock at edge 0 -> out_rst falls exactly at edge 1027 (2 sync + 1 + 1024); out_run rises at the same edge.
REQ-033 In RUN -> out_ppu_ce pulses every 4 cycles, first pulse on the 4th RUN cycle; out_cpu_ce every 12 cycles, first at the 12th; out_apu_ce every 24 cycles, first at the 24th.
REQ-034 Drop in_pll_lock for 1 cycle at SETTLE count 500 -> return to WAIT_LOCK; out_rst stays high; on relock a full 1024-cycle settle is required.
REQ-035 Drop in_pll_lock mid-RUN -> out_rst=1 and all enables low within 3 edges; with macro defined, out_lock_loss_count 0->1; after 300 losses it reads 255.
REQ-036 Assert in_rst mid-RUN on a cycle where out_cpu_ce=1 -> all enables 0 and out_rst=1 immediately (asynchronous); phase counter and toggle read 0 after release.
REQ-037 PPU_DIV=1 -> out_ppu_ce continuously high in RUN; out_cpu_ce every 3 cycles; out_apu_ce every 6 cycles.
